// File: rtl/uart.sv
// uart: memory-mapped 8N1 UART peripheral on one bus slave port.
//
// Register offsets (addr_i[7:0]):
//   0x00 CTRL   rw  bit0 tx_en, bit1 rx_en, bit2 rx_int_en
//   0x04 STATUS     bit0 tx_busy (ro); bit1 rx_valid, bit2 rx_overrun, bit3 frame_err (W1C)
//   0x08 BAUD   rw  bits[15:0] clk cycles per bit, minimum 4
//   0x0C TXDATA wo  bits[7:0], starts a frame when tx_en and the transmitter is free
//   0x10 RXDATA ro  bits[7:0], last accepted byte
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-low reset
//   we_i    bus write strobe
//   addr_i  bus address (low byte decoded)
//   data_i  bus write data
//   data_o  bus read data, combinational from addr_i
//   tx_pin  serial output, idles high
//   rx_pin  serial input, asynchronous
//   int_o   level interrupt, rx_valid & rx_int_en
module uart #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_pin,
  input  logic        rx_pin,
  output logic        int_o
);

  localparam logic [15:0] BAUD_RST = 16'(BAUD_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Registers
  logic        tx_en, rx_en, rx_int_en;
  logic [15:0] baud;
  logic        rx_valid, rx_overrun, frame_err;
  logic [7:0]  rx_data;

  // Bus decode
  logic wr_ctrl, wr_status, wr_baud, wr_txdata;
  assign wr_ctrl   = we_i && (addr_i[7:0] == 8'h00);
  assign wr_status = we_i && (addr_i[7:0] == 8'h04);
  assign wr_baud   = we_i && (addr_i[7:0] == 8'h08);
  assign wr_txdata = we_i && (addr_i[7:0] == 8'h0C);

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:8], data_i[31:16]};

  // ---------------- TX FSM ----------------
  state_t      tx_state, tx_state_nx;
  logic [15:0] tx_cnt, tx_cnt_nx;
  logic [2:0]  tx_idx, tx_idx_nx;
  logic [7:0]  tx_shift, tx_shift_nx;
  logic        tx_tick, tx_busy;

  assign tx_tick = (tx_cnt == 16'd1);
  assign tx_busy = (tx_state != S_IDLE);

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_idx_nx   = tx_idx;
    tx_shift_nx = tx_shift;
    if (tx_state != S_IDLE) tx_cnt_nx = tx_cnt - 16'd1;
    case (tx_state)
      S_IDLE: begin
        if (wr_txdata && tx_en) begin
          tx_state_nx = S_START;
          tx_cnt_nx   = baud;
          tx_shift_nx = data_i[7:0];
        end
      end
      S_START: begin
        if (tx_tick) begin
          tx_state_nx = S_DATA;
          tx_cnt_nx   = baud;
          tx_idx_nx   = '0;
        end
      end
      S_DATA: begin
        if (tx_tick) begin
          tx_cnt_nx   = baud;
          tx_shift_nx = {1'b0, tx_shift[7:1]};
          tx_idx_nx   = tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_tick) begin
          // A TXDATA write on the edge that ends the stop bit starts the
          // next frame directly, so back-to-back frames have no idle gap.
          if (wr_txdata && tx_en) begin
            tx_state_nx = S_START;
            tx_cnt_nx   = baud;
            tx_shift_nx = data_i[7:0];
          end else begin
            tx_state_nx = S_IDLE;
          end
        end
      end
      default: tx_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_idx   <= tx_idx_nx;
      tx_shift <= tx_shift_nx;
    end
  end

  // Decoded from registers only, so reset forces the line high immediately.
  always_comb begin
    tx_pin = 1'b1;
    case (tx_state)
      S_START: tx_pin = 1'b0;
      S_DATA:  tx_pin = tx_shift[0];
      default: tx_pin = 1'b1;
    endcase
  end

  // ---------------- RX path ----------------
  logic rx_s1, rx_s2, rx_s3, rx_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_pin;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  state_t      rx_state, rx_state_nx;
  logic [15:0] rx_cnt, rx_cnt_nx;
  logic [2:0]  rx_idx, rx_idx_nx;
  logic [7:0]  rx_shift, rx_shift_nx;
  logic        rx_tick, rx_good, rx_bad;

  assign rx_tick = (rx_cnt == 16'd1);

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_idx_nx   = rx_idx;
    rx_shift_nx = rx_shift;
    rx_good     = 1'b0;
    rx_bad      = 1'b0;
    if (rx_state != S_IDLE) rx_cnt_nx = rx_cnt - 16'd1;
    case (rx_state)
      S_IDLE: begin
        if (rx_fall) begin
          rx_state_nx = S_START;
          rx_cnt_nx   = baud >> 1;
        end
      end
      S_START: begin
        if (rx_tick) begin
          if (rx_s2) begin
            rx_state_nx = S_IDLE;
          end else begin
            rx_state_nx = S_DATA;
            rx_cnt_nx   = baud;
            rx_idx_nx   = '0;
          end
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_cnt_nx   = baud;
          rx_shift_nx = {rx_s2, rx_shift[7:1]};
          rx_idx_nx   = rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_tick) begin
          rx_state_nx = S_IDLE;
          if (rx_s2) rx_good = 1'b1;
          else       rx_bad  = 1'b1;
        end
      end
      default: rx_state_nx = S_IDLE;
    endcase
    if (!rx_en) begin
      rx_state_nx = S_IDLE;
      rx_good     = 1'b0;
      rx_bad      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_idx   <= rx_idx_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  // ---------------- Register file ----------------
  logic [2:0] clr;
  assign clr = wr_status ? data_i[3:1] : 3'b000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_en      <= 1'b0;
      rx_en      <= 1'b0;
      rx_int_en  <= 1'b0;
      baud       <= BAUD_RST;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      rx_data    <= '0;
    end else begin
      if (wr_ctrl) begin
        tx_en     <= data_i[0];
        rx_en     <= data_i[1];
        rx_int_en <= data_i[2];
      end
      if (wr_baud) baud <= (data_i[15:0] < 16'd4) ? 16'd4 : data_i[15:0];
      // A byte landing on the same edge as the rx_valid clear counts as a
      // fresh byte: it is loaded and no overrun is flagged.
      rx_valid   <= (rx_valid & ~clr[0]) | rx_good;
      rx_overrun <= (rx_overrun & ~clr[1]) | (rx_good & rx_valid & ~clr[0]);
      frame_err  <= (frame_err & ~clr[2]) | rx_bad;
      if (rx_good && (!rx_valid || clr[0])) rx_data <= rx_shift;
    end
  end

  always_comb begin
    data_o = '0;
    case (addr_i[7:0])
      8'h00:   data_o = {29'd0, rx_int_en, rx_en, tx_en};
      8'h04:   data_o = {28'd0, frame_err, rx_overrun, rx_valid, tx_busy};
      8'h08:   data_o = {16'd0, baud};
      8'h10:   data_o = {24'd0, rx_data};
      default: data_o = '0;
    endcase
  end

  assign int_o = rx_valid & rx_int_en;

endmodule

// File: tb/tb_uart.sv
// tb_uart: directed self-checking bench for the uart peripheral.
module tb_uart;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        tx_pin;
  logic        rx_pin;
  logic        int_o;

  int unsigned checks;
  int unsigned errors;

  uart #(.BAUD_DIV(434)) dut (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .tx_pin (tx_pin),
    .rx_pin (rx_pin),
    .int_o  (int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i   = 1'b1;
    addr_i = {24'd0, a};
    data_i = d;
    @(posedge clk);
    #1;
    we_i = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk);
    we_i   = 1'b0;
    addr_i = {24'd0, a};
    #1;
    check(tag, data_o, exp);
  endtask

  // 8 clk cycles per bit, LSB first
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_pin = f[i];
      repeat (7) @(negedge clk);
    end
    @(negedge clk);
    rx_pin = 1'b1;
  endtask

  logic [9:0] tx_frame;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    we_i   = 1'b0;
    addr_i = '0;
    data_i = '0;
    rx_pin = 1'b1;
    tx_frame = {1'b1, 8'hA5, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_tx_pin", {31'd0, tx_pin}, 32'd1);
    check("rst_int_o", {31'd0, int_o}, 32'd0);
    rd_check("rst_baud", 8'h08, 32'd434);
    rd_check("rst_ctrl", 8'h00, 32'd0);
    rd_check("rst_status", 8'h04, 32'd0);
    rd_check("rst_rxdata", 8'h10, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // TX 0xA5 at 4 cycles/bit
    bus_wr(8'h08, 32'd4);
    bus_wr(8'h00, 32'd1);
    rd_check("ctrl_rd", 8'h00, 32'd1);
    bus_wr(8'h0C, 32'hA5);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      we_i   = 1'b0;
      addr_i = 32'h04;
      #1;
      check($sformatf("tx_bit_c%0d", n), {31'd0, tx_pin}, {31'd0, tx_frame[n / 4]});
      check($sformatf("tx_busy_c%0d", n), {31'd0, data_o[0]}, 32'd1);
      if (n == 20) begin
        we_i   = 1'b1;
        addr_i = 32'h0C;
        data_i = 32'hFF;
      end
    end
    @(negedge clk);
    we_i   = 1'b0;
    addr_i = 32'h04;
    #1;
    check("tx_done_busy", {31'd0, data_o[0]}, 32'd0);
    check("tx_done_pin", {31'd0, tx_pin}, 32'd1);
    repeat (5) @(negedge clk);
    #1;
    check("tx_idle_pin", {31'd0, tx_pin}, 32'd1);

    // RX 0x3C at 8 cycles/bit
    bus_wr(8'h08, 32'd8);
    bus_wr(8'h00, 32'h6);
    send_byte(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    rd_check("rx_data_3c", 8'h10, 32'h3C);
    rd_check("rx_status_valid", 8'h04, 32'h2);
    check("rx_int_set", {31'd0, int_o}, 32'd1);
    bus_wr(8'h04, 32'h2);
    rd_check("rx_status_clr", 8'h04, 32'h0);
    check("rx_int_clr", {31'd0, int_o}, 32'd0);

    // Overrun
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    rd_check("ovr_data", 8'h10, 32'h11);
    rd_check("ovr_status", 8'h04, 32'h6);
    bus_wr(8'h04, 32'hE);
    rd_check("ovr_clr", 8'h04, 32'h0);

    // Framing error
    send_byte(8'h55, 1'b0);
    repeat (2) @(negedge clk);
    rd_check("ferr_status", 8'h04, 32'h8);
    rd_check("ferr_data", 8'h10, 32'h11);
    check("ferr_int", {31'd0, int_o}, 32'd0);

    // False start: 2-cycle low pulse
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (2) @(negedge clk);
    rx_pin = 1'b1;
    repeat (20) @(negedge clk);
    rd_check("fstart_status", 8'h04, 32'h8);
    rd_check("fstart_data", 8'h10, 32'h11);
    send_byte(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    rd_check("after_fstart_data", 8'h10, 32'h5A);
    rd_check("after_fstart_status", 8'h04, 32'hA);

    // BAUD floor
    bus_wr(8'h08, 32'd1);
    rd_check("baud_min", 8'h08, 32'd4);

    // Reset mid TX frame
    bus_wr(8'h00, 32'd1);
    bus_wr(8'h0C, 32'h00);
    repeat (6) @(negedge clk);
    #1;
    check("pre_rst_pin", {31'd0, tx_pin}, 32'd0);
    rst = 1'b0;
    #1;
    check("async_rst_pin", {31'd0, tx_pin}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    rd_check("post_rst_status", 8'h04, 32'd0);
    rd_check("post_rst_baud", 8'h08, 32'd434);
    rd_check("post_rst_ctrl", 8'h00, 32'd0);
    rd_check("post_rst_rxdata", 8'h10, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
